tag_dispatcher: RTL and testbench
=================================

Name: tag_dispatcher

Overview:
- Front-end scheduler for the reorder circular buffer and parallel filter cores.
- Accepts the packet filter IP AXI-stream input, allocates sequential reorder tags (0..CIRCULAR_BUFFER_SIZE-1, wrapping), and round-robin arbitrates each whole packet to one idle filter core.
- Tracks outstanding tags and stalls input when every circular buffer slot is reserved.
- Slots are credited back by the circular buffer's per-packet release pulse.

Parameters:
- TAG_WIDTH, 6, reorder tag width; must satisfy 2**TAG_WIDTH >= CIRCULAR_BUFFER_SIZE.
- CIRCULAR_BUFFER_SIZE, 50, number of circular buffer slots, which is also the number of tags.
- DATA_WIDTH, 64, AXI data width in bits.
- NUM_CORES, 4, number of filter cores; minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_TDATA  in  DATA_WIDTH  input stream data
- in_TKEEP  in  DATA_WIDTH/8  forwarded unchanged
- in_TLAST  in  1  last beat of packet
- in_TVALID  in  1  input valid
- in_TREADY  out  1  input ready
- core_TDATA  out  DATA_WIDTH  broadcast data to all cores
- core_TKEEP  out  DATA_WIDTH/8  broadcast keep
- core_TLAST  out  1  broadcast last
- core_TVALID  out  NUM_CORES  one-hot valid to the granted core
- core_TREADY  in  NUM_CORES  per-core ready
- core_idle  in  NUM_CORES  core can accept a new packet
- core_reorder_tag  out  TAG_WIDTH  tag of the packet currently streaming
- tag_release  in  1  one-cycle pulse: circular buffer retired one packet (output TLAST or reject skip)
- outstanding  out  TAG_WIDTH+1  tags currently reserved
- release_err  out  1  sticky; set when a release arrives with outstanding==0

Behaviour:
- Reset values: in_TREADY=0, core_TVALID=0, core_reorder_tag=0, next_tag=0, rr_ptr=0, outstanding=0, release_err=0, state=IDLE.
- The reset is synchronous. Reset asserted mid-packet abandons the packet and returns to IDLE. Partial beats already sent are not recovered.
- State IDLE:
  - in_TREADY=0; core_TVALID=0.
  - Grant condition: in_TVALID && outstanding<CIRCULAR_BUFFER_SIZE && |core_idle.
  - Grant target: the first core at or after rr_ptr (modulo NUM_CORES) with core_idle=1.
  - On grant, register grant index and core_reorder_tag<=next_tag, increment outstanding, and go to STREAM.
  - Grant latency: 1 cycle from in_TVALID to the first possible transfer.
- State STREAM:
  - Combinational pass-through: core_TVALID[grant]=in_TVALID, other bits 0; in_TREADY=core_TREADY[grant]; data, keep and last broadcast.
  - A beat transfers when in_TVALID && core_TREADY[grant].
  - On a transfer with in_TLAST: next_tag<=(next_tag==CIRCULAR_BUFFER_SIZE-1)?0:next_tag+1, rr_ptr<=(grant==NUM_CORES-1)?0:grant+1, state<=IDLE.
  - A single-beat packet is legal (IDLE -> STREAM -> IDLE).
- Outstanding counter:
  - +1 on grant; -1 on tag_release.
  - Simultaneous grant and release leaves the value unchanged.
  - Release while outstanding==0: counter holds at 0 and release_err is set (cleared only by rst).
- Full condition: outstanding==CIRCULAR_BUFFER_SIZE. IDLE holds with in_TREADY=0 until a release. A release in the same cycle does not enable a grant; the grant happens the next cycle (grant uses the registered count).
- core_reorder_tag is stable for the entire packet and holds its last value in IDLE.
- core_idle is sampled only in IDLE. A core dropping core_idle mid-packet has no effect on the stream.

Decomposition:
- Shared package: state enum (IDLE, STREAM); tag-increment-with-wrap function parameterised on CIRCULAR_BUFFER_SIZE; the TAG_WIDTH/CIRCULAR_BUFFER_SIZE legality check.
- One sub-module: rr_arbiter (NUM_CORES request vector plus rotating pointer in; one-hot grant and index out; purely combinational). The dispatcher owns the pointer register.

Test Plan:
- All cores idle, one 3-beat packet, core_TREADY=all 1 -> first beat on core_TVALID[0] in cycle 2 with tag 0; outstanding=1; back to IDLE after beat 3.
- Five back-to-back 2-beat packets -> cores 0,1,2,3,0 with tags 0,1,2,3,4; outstanding=5.
- core_idle=4'b0100, rr_ptr=0 -> core 2 granted; rr_ptr becomes 3.
- 50 packets with no release -> outstanding=50, 51st packet stalls with in_TREADY=0; one tag_release pulse -> granted the next cycle with tag 0 (wrap from 49).
- tag_release in the same cycle as a grant at outstanding=10 -> outstanding stays 10. tag_release at outstanding=0 -> release_err=1 and count remains 0.
- rst asserted during beat 2 of a 4-beat packet -> next cycle all outputs at reset values and the next packet gets tag 0 on core 0.

Source files
------------

// File: rtl/tag_dispatcher_pkg.sv
// Shared types and helpers for the tag dispatcher: FSM states, tag wrap
// arithmetic and the tag-width legality check.
package tag_dispatcher_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Next tag in the 0..size-1 ring.
  function automatic int unsigned tag_inc(input int unsigned tag, input int unsigned size);
    if (tag == size - 32'd1) begin
      return 32'd0;
    end else begin
      return tag + 32'd1;
    end
  endfunction

  function automatic bit tag_width_ok(input int unsigned tag_width, input int unsigned size);
    return (64'd1 << tag_width) >= 64'(size);
  endfunction

endpackage

// File: rtl/tag_dispatcher_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// searching modulo NUM_CORES.
module tag_dispatcher_rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IW        = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic [NUM_CORES-1:0] grant,
  output logic [IW-1:0]        grant_idx,
  output logic                 grant_valid
);

  int unsigned cand_s;
  logic        found_s;

  // Scan the request vector starting at the rotating pointer.
  always_comb begin
    grant       = {NUM_CORES{1'b0}};
    grant_idx   = {IW{1'b0}};
    found_s     = 1'b0;
    cand_s      = 32'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand_s = (32'(ptr) + 32'(i)) % 32'(NUM_CORES);
      if (!found_s && req[cand_s]) begin
        found_s   = 1'b1;
        grant_idx = cand_s[IW-1:0];
      end else begin
        found_s   = found_s;
      end
    end
    grant[grant_idx] = found_s;
    grant_valid      = found_s;
  end

endmodule

// File: rtl/tag_dispatcher.sv
// Front-end scheduler: allocates reorder tags, routes whole packets to an
// idle filter core round-robin, and throttles on circular-buffer occupancy.
module tag_dispatcher
  import tag_dispatcher_pkg::*;
#(
  parameter int TAG_WIDTH            = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 50,
  parameter int DATA_WIDTH           = 64,
  parameter int NUM_CORES            = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_TDATA,
  input  logic [DATA_WIDTH/8-1:0] in_TKEEP,
  input  logic                    in_TLAST,
  input  logic                    in_TVALID,
  output logic                    in_TREADY,
  output logic [DATA_WIDTH-1:0]   core_TDATA,
  output logic [DATA_WIDTH/8-1:0] core_TKEEP,
  output logic                    core_TLAST,
  output logic [NUM_CORES-1:0]    core_TVALID,
  input  logic [NUM_CORES-1:0]    core_TREADY,
  input  logic [NUM_CORES-1:0]    core_idle,
  output logic [TAG_WIDTH-1:0]    core_reorder_tag,
  input  logic                    tag_release,
  output logic [TAG_WIDTH:0]      outstanding,
  output logic                    release_err
);

  localparam int IW = $clog2(NUM_CORES);
  localparam int CW = TAG_WIDTH + 1;
  localparam logic [CW-1:0] CBS_C = CW'(CIRCULAR_BUFFER_SIZE);

  if (!tag_width_ok(TAG_WIDTH, CIRCULAR_BUFFER_SIZE) || NUM_CORES < 2) begin : g_param_err
    $error("tag_dispatcher: illegal TAG_WIDTH/CIRCULAR_BUFFER_SIZE/NUM_CORES");
  end

  state_t                state_r, state_nxt_s;
  logic [IW-1:0]         grant_idx_r, grant_idx_nxt_s;
  logic [NUM_CORES-1:0]  grant_oh_r, grant_oh_nxt_s;
  logic [IW-1:0]         rr_ptr_r, rr_ptr_nxt_s;
  logic [TAG_WIDTH-1:0]  next_tag_r, next_tag_nxt_s;
  logic [TAG_WIDTH-1:0]  tag_r, tag_nxt_s;
  logic [CW-1:0]         outstanding_r, outstanding_nxt_s;
  logic                  release_err_r, release_err_nxt_s;

  logic [NUM_CORES-1:0]  arb_grant_s;
  logic [IW-1:0]         arb_idx_s;
  logic                  arb_valid_s;
  logic                  grant_fire_s;
  logic                  ready_sel_s;
  logic                  last_xfer_s;

  tag_dispatcher_rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IW        (IW)
  ) u_rr_arbiter (
    .req         (core_idle),
    .ptr         (rr_ptr_r),
    .grant       (arb_grant_s),
    .grant_idx   (arb_idx_s),
    .grant_valid (arb_valid_s)
  );

  // Grant decision uses the registered count, so a same-cycle release cannot unblock it.
  assign grant_fire_s = (state_r == IDLE) && in_TVALID && (outstanding_r < CBS_C) && arb_valid_s;
  assign ready_sel_s  = |(core_TREADY & grant_oh_r);
  assign last_xfer_s  = (state_r == STREAM) && in_TVALID && ready_sel_s && in_TLAST;

  assign core_TDATA       = in_TDATA;
  assign core_TKEEP       = in_TKEEP;
  assign core_TLAST       = in_TLAST;
  assign core_reorder_tag = tag_r;
  assign outstanding      = outstanding_r;
  assign release_err      = release_err_r;

  // FSM next state, handshake pass-through and tag/pointer advance.
  always_comb begin
    state_nxt_s     = state_r;
    grant_idx_nxt_s = grant_idx_r;
    grant_oh_nxt_s  = grant_oh_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    next_tag_nxt_s  = next_tag_r;
    tag_nxt_s       = tag_r;
    in_TREADY       = 1'b0;
    core_TVALID     = {NUM_CORES{1'b0}};
    case (state_r)
      IDLE: begin
        if (grant_fire_s) begin
          grant_idx_nxt_s = arb_idx_s;
          grant_oh_nxt_s  = arb_grant_s;
          tag_nxt_s       = next_tag_r;
          state_nxt_s     = STREAM;
        end else begin
          state_nxt_s     = IDLE;
        end
      end
      STREAM: begin
        in_TREADY   = ready_sel_s;
        core_TVALID = grant_oh_r & {NUM_CORES{in_TVALID}};
        if (last_xfer_s) begin
          next_tag_nxt_s = TAG_WIDTH'(tag_inc(32'(next_tag_r), CIRCULAR_BUFFER_SIZE));
          rr_ptr_nxt_s   = (grant_idx_r == IW'(NUM_CORES - 1)) ? {IW{1'b0}} : grant_idx_r + IW'(1);
          state_nxt_s    = IDLE;
        end else begin
          state_nxt_s    = STREAM;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Occupancy tracking; a release with nothing reserved is flagged and ignored.
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    release_err_nxt_s = release_err_r;
    case ({grant_fire_s, tag_release})
      2'b10: outstanding_nxt_s = outstanding_r + CW'(1);
      2'b01: begin
        if (outstanding_r == {CW{1'b0}}) begin
          release_err_nxt_s = 1'b1;
        end else begin
          outstanding_nxt_s = outstanding_r - CW'(1);
        end
      end
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      grant_idx_r   <= {IW{1'b0}};
      grant_oh_r    <= {NUM_CORES{1'b0}};
      rr_ptr_r      <= {IW{1'b0}};
      next_tag_r    <= {TAG_WIDTH{1'b0}};
      tag_r         <= {TAG_WIDTH{1'b0}};
      outstanding_r <= {CW{1'b0}};
      release_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      grant_idx_r   <= grant_idx_nxt_s;
      grant_oh_r    <= grant_oh_nxt_s;
      rr_ptr_r      <= rr_ptr_nxt_s;
      next_tag_r    <= next_tag_nxt_s;
      tag_r         <= tag_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      release_err_r <= release_err_nxt_s;
    end
  end

endmodule

// File: tb/tb_tag_dispatcher.sv
// Self-checking bench for tag_dispatcher: directed scenarios plus random
// traffic, all compared cycle by cycle against a packet-level model.
module tb_tag_dispatcher;

  localparam int TW  = 6;
  localparam int CBS = 50;
  localparam int DW  = 64;
  localparam int NC  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   in_TDATA;
  logic [DW/8-1:0] in_TKEEP;
  logic            in_TLAST;
  logic            in_TVALID;
  logic            in_TREADY;
  logic [DW-1:0]   core_TDATA;
  logic [DW/8-1:0] core_TKEEP;
  logic            core_TLAST;
  logic [NC-1:0]   core_TVALID;
  logic [NC-1:0]   core_TREADY;
  logic [NC-1:0]   core_idle;
  logic [TW-1:0]   core_reorder_tag;
  logic            tag_release;
  logic [TW:0]     outstanding;
  logic            release_err;

  always #5 clk = ~clk;

  tag_dispatcher #(
    .TAG_WIDTH            (TW),
    .CIRCULAR_BUFFER_SIZE (CBS),
    .DATA_WIDTH           (DW),
    .NUM_CORES            (NC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_TDATA         (in_TDATA),
    .in_TKEEP         (in_TKEEP),
    .in_TLAST         (in_TLAST),
    .in_TVALID        (in_TVALID),
    .in_TREADY        (in_TREADY),
    .core_TDATA       (core_TDATA),
    .core_TKEEP       (core_TKEEP),
    .core_TLAST       (core_TLAST),
    .core_TVALID      (core_TVALID),
    .core_TREADY      (core_TREADY),
    .core_idle        (core_idle),
    .core_reorder_tag (core_reorder_tag),
    .tag_release      (tag_release),
    .outstanding      (outstanding),
    .release_err      (release_err)
  );

  int total = 0;
  int bad   = 0;

  // Packet-level reference model
  bit m_busy;
  int m_core;
  int m_tag;
  int m_next;
  int m_rr;
  int m_out;
  bit m_err;
  bit m_xfer;

  logic [NC-1:0] s_valid;
  logic [TW-1:0] s_tag;

  task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_core = 0; m_tag = 0; m_next = 0; m_rr = 0; m_out = 0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit granted;
    granted = 1'b0;
    m_xfer  = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (!m_busy) begin
        if (in_TVALID && m_out < CBS && core_idle != '0) begin
          for (int k = NC - 1; k >= 0; k--)
            if (core_idle[(m_rr + k) % NC]) m_core = (m_rr + k) % NC;
          m_tag   = m_next;
          m_busy  = 1'b1;
          granted = 1'b1;
        end
      end else if (in_TVALID && core_TREADY[m_core]) begin
        m_xfer = 1'b1;
        if (in_TLAST) begin
          m_next = (m_next + 1) % CBS;
          m_rr   = (m_core + 1) % NC;
          m_busy = 1'b0;
        end
      end
      if (tag_release && !granted) begin
        if (m_out == 0) m_err = 1'b1;
        else m_out--;
      end else if (granted && !tag_release) begin
        m_out++;
      end
    end
  endtask

  // One clock: compare outputs mid-cycle, advance the model, step past the edge.
  task automatic cyc();
    logic [NC-1:0] ev;
    logic          er;
    #4;
    ev = '0;
    er = 1'b0;
    if (m_busy) begin
      if (in_TVALID) ev[m_core] = 1'b1;
      er = core_TREADY[m_core];
    end
    s_valid = core_TVALID;
    s_tag   = core_reorder_tag;
    check_val("tready", 64'(in_TREADY), 64'(er));
    check_val("tvalid", 64'(core_TVALID), 64'(ev));
    check_val("tag", 64'(core_reorder_tag), 64'(m_tag));
    check_val("outstanding", 64'(outstanding), 64'(m_out));
    check_val("release_err", 64'(release_err), 64'(m_err));
    check_val("tdata", core_TDATA, in_TDATA);
    check_val("tkeep_tlast", 64'({core_TKEEP, core_TLAST}), 64'({in_TKEEP, in_TLAST}));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_TVALID = 1'b0; in_TLAST = 1'b0; tag_release = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic send_pkt(input int beats, input logic [NC-1:0] idle,
                          output logic [NC-1:0] ov, output int ot);
    int sent;
    int guard;
    sent = 0; guard = 0; ov = '0; ot = -1;
    core_idle = idle; core_TREADY = '1; in_TVALID = 1'b1;
    while (sent < beats && guard < 300) begin
      in_TLAST = (sent == beats - 1);
      in_TDATA = {$urandom, $urandom};
      in_TKEEP = 8'($urandom);
      cyc();
      if (m_xfer) begin
        if (sent == 0) begin
          ov = s_valid;
          ot = int'(s_tag);
        end
        sent++;
      end
      guard++;
    end
    in_TVALID = 1'b0;
    in_TLAST  = 1'b0;
    check_val("pkt_beats", 64'(sent), 64'(beats));
  endtask

  logic [NC-1:0] ov;
  int            ot;

  initial begin
    rst = 1'b1; in_TDATA = '0; in_TKEEP = '0; in_TLAST = 1'b0; in_TVALID = 1'b0;
    core_TREADY = '0; core_idle = '0; tag_release = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    do_reset();
    check_val("rst_tready", 64'(in_TREADY), 64'd0);
    check_val("rst_tvalid", 64'(core_TVALID), 64'd0);
    check_val("rst_outstanding", 64'(outstanding), 64'd0);

    // single 3-beat packet
    send_pkt(3, 4'b1111, ov, ot);
    check_val("p1_core", 64'(ov), 64'd1);
    check_val("p1_tag", 64'(ot), 64'd0);
    check_val("p1_outstanding", 64'(outstanding), 64'd1);
    cyc();

    // five back-to-back 2-beat packets
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_pkt(2, 4'b1111, ov, ot);
      check_val("b2b_core", 64'(ov), 64'd1 << (i % NC));
      check_val("b2b_tag", 64'(ot), 64'(i));
    end
    check_val("b2b_outstanding", 64'(outstanding), 64'd5);

    // sparse idle mask skips ahead, pointer follows the winner
    do_reset();
    send_pkt(1, 4'b0100, ov, ot);
    check_val("sparse_core", 64'(ov), 64'd4);
    send_pkt(1, 4'b1111, ov, ot);
    check_val("rr_after_sparse", 64'(ov), 64'd8);

    // fill every slot, stall, release one, wrap to tag 0
    do_reset();
    for (int i = 0; i < CBS; i++) send_pkt(1, 4'b1111, ov, ot);
    check_val("full_outstanding", 64'(outstanding), 64'(CBS));
    in_TVALID = 1'b1; in_TLAST = 1'b1;
    repeat (3) cyc();
    check_val("full_stall", 64'(in_TREADY), 64'd0);
    tag_release = 1'b1;
    cyc();
    tag_release = 1'b0;
    cyc();
    cyc();
    check_val("wrap_tag", 64'(s_tag), 64'd0);
    check_val("wrap_core", 64'(s_valid), 64'd4);
    in_TVALID = 1'b0; in_TLAST = 1'b0;

    // simultaneous grant and release; then release underflow
    do_reset();
    for (int i = 0; i < 10; i++) send_pkt(1, 4'b1111, ov, ot);
    in_TVALID = 1'b1; in_TLAST = 1'b1; tag_release = 1'b1;
    cyc();
    tag_release = 1'b0;
    check_val("grant_rel_outstanding", 64'(outstanding), 64'd10);
    cyc();
    in_TVALID = 1'b0; in_TLAST = 1'b0;
    tag_release = 1'b1;
    repeat (10) cyc();
    check_val("drained", 64'(outstanding), 64'd0);
    cyc();
    tag_release = 1'b0;
    check_val("underflow_err", 64'(release_err), 64'd1);
    check_val("underflow_cnt", 64'(outstanding), 64'd0);

    // reset in the middle of a 4-beat packet
    do_reset();
    core_idle = 4'b1111; core_TREADY = 4'b1111;
    in_TVALID = 1'b1; in_TLAST = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; in_TVALID = 1'b0;
    #4;
    check_val("mid_rst_tvalid", 64'(core_TVALID), 64'd0);
    check_val("mid_rst_tready", 64'(in_TREADY), 64'd0);
    check_val("mid_rst_outstanding", 64'(outstanding), 64'd0);
    check_val("mid_rst_tag", 64'(core_reorder_tag), 64'd0);
    @(posedge clk);
    #1;
    send_pkt(2, 4'b1111, ov, ot);
    check_val("post_rst_core", 64'(ov), 64'd1);
    check_val("post_rst_tag", 64'(ot), 64'd0);

    // random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      in_TVALID   = ($urandom_range(0, 9) < 7);
      in_TLAST    = ($urandom_range(0, 9) < 3);
      in_TDATA    = {$urandom, $urandom};
      in_TKEEP    = 8'($urandom);
      core_TREADY = NC'($urandom);
      core_idle   = NC'($urandom);
      tag_release = ($urandom_range(0, 99) < 12);
      rst         = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
